// File: rtl/eei.sv
// Execution-environment definitions shared by the integer pipeline and its
// functional units: register width, the XLEN word type and the mul/div arbiter FSM states.
package eei;
  localparam int XLEN = 64;

  typedef logic [XLEN-1:0] UIntX;

  typedef enum logic [1:0] {
    MDA_IDLE  = 2'd0,
    MDA_ISSUE = 2'd1,
    MDA_WAIT  = 2'd2
  } mda_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: scans from ptr upward (wrapping) and grants the first
// eligible requester. Purely combinational, so callers own the pointer.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx,
  output logic          any
);
  localparam logic [IW:0] N_EXT = (IW + 1)'(N);

  logic [IW:0] idx_ext;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    idx_ext      = '0;
    for (int k = 0; k < N; k++) begin
      idx_ext = {1'b0, ptr} + (IW + 1)'(k);
      if (idx_ext >= N_EXT) idx_ext = idx_ext - N_EXT;
      if (!any && eligible[idx_ext[IW-1:0]]) begin
        any                              = 1'b1;
        grant_idx                        = idx_ext[IW-1:0];
        grant_onehot[idx_ext[IW-1:0]]    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/muldiv_arbiter.sv
// Shares one multiply/divide unit between NREQ requesters, one operation in
// flight, with a one-entry response buffer per requester and flush support.
module muldiv_arbiter
  import eei::*;
#(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  // Handshake rule on every valid/ready pair: a transfer happens on the clk
  // edge where valid and ready are both high; valid may not depend on ready.
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][2:0]       req_funct3,
  input  logic [NREQ-1:0]            req_is_op32,
  input  logic [NREQ-1:0][XLEN-1:0]  req_op1,
  input  logic [NREQ-1:0][XLEN-1:0]  req_op2,
  output logic [NREQ-1:0]            resp_valid,
  output logic [NREQ-1:0][XLEN-1:0]  resp_result,
  input  logic [NREQ-1:0]            resp_ready,
  input  logic [NREQ-1:0]            flush,
  output logic                       mdu_valid,
  output logic [2:0]                 mdu_funct3,
  output logic                       mdu_is_op32,
  output UIntX                       mdu_op1,
  output UIntX                       mdu_op2,
  input  logic                       mdu_ready,
  input  logic                       mdu_rvalid,
  input  UIntX                       mdu_result,
  output logic [15:0]                busy_cycles,
  output mda_state_e                 fsm_state
);
  mda_state_e      state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] pick_onehot;
  logic            pick_any;
  logic            kill;
  logic [2:0]      op_funct3;
  logic            op_is_op32;
  UIntX            op1_q;
  UIntX            op2_q;
  logic            rsp_commit;

  // A flushed requester is never granted; a full buffer only blocks its owner.
  assign eligible = req_valid & ~flush & (~resp_valid | resp_ready);

  rr_arbiter #(.N(NREQ)) u_rr (
    .eligible     (eligible),
    .ptr          (rr_ptr),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx),
    .any          (pick_any)
  );

  assign req_ready   = (state == MDA_IDLE && !rst) ? pick_onehot : '0;
  assign mdu_valid   = (state == MDA_ISSUE) && !rst;
  assign mdu_funct3  = op_funct3;
  assign mdu_is_op32 = op_is_op32;
  assign mdu_op1     = op1_q;
  assign mdu_op2     = op2_q;
  assign fsm_state   = state;
  assign rsp_commit  = (state == MDA_WAIT) && mdu_rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MDA_IDLE;
      rr_ptr      <= '0;
      gnt_idx     <= '0;
      kill        <= 1'b0;
      op_funct3   <= '0;
      op_is_op32  <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      busy_cycles <= '0;
    end else begin
      case (state)
        MDA_IDLE: begin
          if (pick_any) begin
            state      <= MDA_ISSUE;
            gnt_idx    <= pick_idx;
            op_funct3  <= req_funct3[pick_idx];
            op_is_op32 <= req_is_op32[pick_idx];
            op1_q      <= req_op1[pick_idx];
            op2_q      <= req_op2[pick_idx];
            rr_ptr     <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            kill       <= 1'b0;
          end
        end
        MDA_ISSUE: begin
          if (mdu_ready) state <= MDA_WAIT;
          if (flush[gnt_idx]) kill <= 1'b1;
        end
        MDA_WAIT: begin
          // The unit cannot be aborted, so a flushed operation runs to completion.
          if (mdu_rvalid) begin
            state <= MDA_IDLE;
            kill  <= 1'b0;
          end else if (flush[gnt_idx]) begin
            kill <= 1'b1;
          end
        end
        default: state <= MDA_IDLE;
      endcase
      if (state != MDA_IDLE && busy_cycles != 16'hFFFF) busy_cycles <= busy_cycles + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst) begin
        resp_valid[i]  <= 1'b0;
        resp_result[i] <= '0;
      end else if (rsp_commit && gnt_idx == IW'(i) && !kill && !flush[i]) begin
        resp_valid[i]  <= 1'b1;
        resp_result[i] <= mdu_result;
      end else if (resp_valid[i] && (resp_ready[i] || flush[i])) begin
        resp_valid[i]  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed and randomized bench for muldiv_arbiter with a behavioural
// multiply/divide unit and a per-requester expected-result queue.
module tb_muldiv_arbiter;
  import eei::*;

  localparam int NREQ = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NREQ-1:0]           req_valid, req_ready, req_is_op32;
  logic [NREQ-1:0][2:0]      req_funct3;
  logic [NREQ-1:0][63:0]     req_op1, req_op2, resp_result;
  logic [NREQ-1:0]           resp_valid, resp_ready, flush;
  logic                      mdu_valid, mdu_is_op32, mdu_ready, mdu_rvalid;
  logic [2:0]                mdu_funct3;
  logic [63:0]               mdu_op1, mdu_op2, mdu_result;
  logic [15:0]               busy_cycles;
  mda_state_e                fsm_state;

  int nvec = 0;
  int nerr = 0;
  logic [63:0] exp_q[NREQ][$];

  // behavioural unit state: mode 0 ready high, 1 random, 2 held low; lat < 0 random
  int          mdu_mode = 0;
  int          mdu_lat  = 0;
  int          mdu_cnt  = 0;
  logic        mdu_busy = 1'b0;
  logic [63:0] mdu_res  = '0;
  logic        spur     = 1'b0;
  logic [NREQ-1:0] last_acc = '0;

  muldiv_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_is_op32(req_is_op32), .req_op1(req_op1), .req_op2(req_op2),
    .resp_valid(resp_valid), .resp_result(resp_result), .resp_ready(resp_ready),
    .flush(flush),
    .mdu_valid(mdu_valid), .mdu_funct3(mdu_funct3), .mdu_is_op32(mdu_is_op32),
    .mdu_op1(mdu_op1), .mdu_op2(mdu_op2), .mdu_ready(mdu_ready),
    .mdu_rvalid(mdu_rvalid), .mdu_result(mdu_result),
    .busy_cycles(busy_cycles), .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // RISC-V M-extension results computed from the architectural definitions.
  function automatic logic [63:0] ref_op(input logic [2:0] f, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [31:0]  a32, b32, r32;
    logic [63:0]  r;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      case (f)
        3'd4: r32 = (b32 == 0) ? 32'hFFFF_FFFF :
                    (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) ? a32 :
                    32'($signed(a32) / $signed(b32));
        3'd5: r32 = (b32 == 0) ? 32'hFFFF_FFFF : a32 / b32;
        3'd6: r32 = (b32 == 0) ? a32 :
                    (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) ? 32'h0 :
                    32'($signed(a32) % $signed(b32));
        3'd7: r32 = (b32 == 0) ? a32 : a32 % b32;
        default: r32 = a32 * b32;
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (f)
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'h0, b};       r = p[127:64]; end
      3'd3: begin p = {64'h0, a} * {64'h0, b};             r = p[127:64]; end
      3'd4: r = (b == 0) ? '1 : (a == 64'h8000_0000_0000_0000 && b == '1) ? a :
                64'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: r = (b == 0) ? a : (a == 64'h8000_0000_0000_0000 && b == '1) ? 64'h0 :
                64'($signed(a) % $signed(b));
      3'd7: r = (b == 0) ? a : a % b;
      default: r = a * b;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 3))
      0: return 64'h0;
      1: return 64'($urandom_range(0, 20));
      2: return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    nvec++;
    assert (got === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  // One clock: scoreboard on handshakes, behavioural unit, per-cycle protocol checks.
  task automatic tick();
    logic [NREQ-1:0] acc, rsp, hold;
    logic            hs;
    @(posedge clk);
    acc  = req_valid & req_ready;
    rsp  = resp_valid & resp_ready;
    hold = resp_valid & ~resp_ready & ~flush & {NREQ{~rst}};
    hs   = mdu_valid & mdu_ready;
    last_acc = acc;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) exp_q[i].push_back(ref_op(req_funct3[i], req_is_op32[i], req_op1[i], req_op2[i]));
      if (rsp[i]) begin
        nvec++;
        assert (exp_q[i].size() != 0) else begin
          nerr++;
          $error("FAIL sb_unexpected_resp%0d: observed %0h expected no response", i, resp_result[i]);
        end
        if (exp_q[i].size() != 0) chk($sformatf("sb_result%0d", i), resp_result[i], exp_q[i].pop_front());
      end
    end
    if (hs) begin
      nvec++;
      assert (!mdu_busy) else begin
        nerr++;
        $error("FAIL one_in_flight: observed 2 operations expected 1");
      end
    end
    if (rst) mdu_busy = 1'b0;
    else if (hs) begin
      mdu_busy = 1'b1;
      mdu_cnt  = (mdu_lat < 0) ? int'($urandom_range(0, 3)) : mdu_lat;
      mdu_res  = ref_op(mdu_funct3, mdu_is_op32, mdu_op1, mdu_op2);
    end
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hold[i] && exp_q[i].size() != 0) begin
        chk($sformatf("resp_hold_valid%0d", i), resp_valid[i], 1);
        chk($sformatf("resp_hold_result%0d", i), resp_result[i], exp_q[i][0]);
      end
    end
    mdu_rvalid = 1'b0;
    mdu_result = {$urandom, $urandom};
    if (mdu_busy) begin
      if (mdu_cnt == 0) begin
        mdu_rvalid = 1'b1;
        mdu_result = mdu_res;
        mdu_busy   = 1'b0;
      end else mdu_cnt--;
    end else if (spur) begin
      mdu_rvalid = 1'b1;
      spur       = 1'b0;
    end
    case (mdu_mode)
      0: mdu_ready = 1'b1;
      1: mdu_ready = 1'($urandom_range(0, 1));
      default: mdu_ready = 1'b0;
    endcase
    chk("req_ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
    chk("req_ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
  endtask

  // driver tasks
  task automatic set_req(input int i, input logic [2:0] f, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
    req_funct3[i]  = f;
    req_is_op32[i] = w;
    req_op1[i]     = a;
    req_op2[i]     = b;
    req_valid[i]   = 1'b1;
  endtask

  task automatic accept(input int i);
    for (int n = 0; n < 50; n++) begin
      tick();
      if (last_acc[i]) break;
    end
    chk($sformatf("accept%0d", i), last_acc[i], 1);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp(input int i, input logic [63:0] expv, input string tag, output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (resp_valid[i]) begin
        n = k;
        break;
      end
    end
    chk({tag, "_resp_valid"}, resp_valid[i], 1);
    chk({tag, "_result"}, resp_result[i], expv);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    flush      = '0;
    resp_ready = '1;
    spur       = 1'b0;
    tick();
    tick();
    for (int i = 0; i < NREQ; i++) exp_q[i].delete();
  endtask

  initial begin
    int          n;
    logic        seen0;
    logic [63:0] got0, a, b;

    rst = 1'b1; req_valid = '0; req_funct3 = '0; req_is_op32 = '0;
    req_op1 = '0; req_op2 = '0; resp_ready = '1; flush = '0;
    mdu_ready = 1'b1; mdu_rvalid = 1'b0; mdu_result = '0;

    // reset state
    do_reset();
    chk("rst_state", 64'(fsm_state), 64'(MDA_IDLE));
    chk("rst_mdu_valid", mdu_valid, 0);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_resp_result0", resp_result[0], 0);
    chk("rst_resp_result1", resp_result[1], 0);
    chk("rst_busy", 64'(busy_cycles), 0);
    chk("rst_mdu_op1", mdu_op1, 0);
    chk("rst_mdu_op2", mdu_op2, 0);
    chk("rst_mdu_funct3", 64'(mdu_funct3), 0);
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", 64'(req_ready), 0);
    req_valid = '0;
    rst = 1'b0;

    // MUL 6*7 on requester 0, latency and busy count
    set_req(0, 3'd0, 1'b0, 64'd6, 64'd7);
    #1;
    chk("t032_req_ready", 64'(req_ready), 64'b01);
    tick();
    chk("t032_accept", 64'(last_acc), 64'b01);
    req_valid[0] = 1'b0;
    chk("t032_mdu_valid", mdu_valid, 1);
    chk("t032_mdu_op1", mdu_op1, 6);
    wait_resp(0, 64'd42, "t032", n);
    chk("t032_latency", 64'(n), 2);
    chk("t032_resp_valid1", resp_valid[1], 0);
    chk("t032_busy", 64'(busy_cycles), 2);
    tick();
    chk("t032_drained", resp_valid[0], 0);

    // simultaneous requests from pointer 0
    do_reset();
    rst = 1'b0;
    set_req(0, 3'd0, 1'b0, 64'd11, 64'd12);
    set_req(1, 3'd3, 1'b0, '1, 64'd2);
    #1;
    chk("t033_first_ready", 64'(req_ready), 64'b01);
    tick();
    chk("t033_first_grant", 64'(last_acc), 64'b01);
    req_valid[0] = 1'b0;
    wait_resp(0, 64'd132, "t033_r0", n);
    tick();
    chk("t033_second_grant", 64'(last_acc), 64'b10);
    req_valid[1] = 1'b0;
    wait_resp(1, 64'd1, "t033_r1", n);
    tick();
    req_valid = 2'b11;
    #1;
    chk("t033_ptr_back_to_0", 64'(req_ready), 64'b01);
    req_valid = '0;

    // DIVU by zero held in a stalled buffer while requester 0 proceeds
    resp_ready[1] = 1'b0;
    set_req(1, 3'd5, 1'b0, 64'd5, 64'd0);
    accept(1);
    wait_resp(1, '1, "t034_divu0", n);
    set_req(0, 3'd0, 1'b0, 64'd3, 64'd3);
    seen0 = 1'b0;
    got0  = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (last_acc[0]) req_valid[0] = 1'b0;
      if (resp_valid[0] && !seen0) begin
        seen0 = 1'b1;
        got0  = resp_result[0];
      end
      chk("t034_hold_valid1", resp_valid[1], 1);
      chk("t034_hold_result1", resp_result[1], '1);
    end
    chk("t034_req0_served", seen0, 1);
    chk("t034_req0_result", got0, 64'd9);
    resp_ready[1] = 1'b1;
    tick();
    chk("t034_released", resp_valid[1], 0);

    // flush in Wait discards the result
    mdu_lat = 3;
    set_req(0, 3'd4, 1'b0, -64'sd20, 64'd3);
    accept(0);
    tick();
    chk("t035_in_wait", 64'(fsm_state), 64'(MDA_WAIT));
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    exp_q[0].delete();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t035_no_resp", resp_valid[0], 0);
      if (fsm_state == MDA_IDLE) break;
    end
    chk("t035_back_idle", 64'(fsm_state), 64'(MDA_IDLE));
    tick();
    chk("t035_still_no_resp", resp_valid[0], 0);

    // flush of a full buffer, and flush suppressing a grant
    mdu_lat = 0;
    resp_ready[0] = 1'b0;
    set_req(0, 3'd7, 1'b0, 64'd17, 64'd5);
    accept(0);
    wait_resp(0, 64'd2, "t021", n);
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    exp_q[0].delete();
    chk("t021_buffer_cleared", resp_valid[0], 0);
    resp_ready[0] = 1'b1;
    flush[0] = 1'b1;
    set_req(0, 3'd0, 1'b0, 64'd2, 64'd2);
    #1;
    chk("t022_flush_ready", 64'(req_ready), 0);
    tick();
    chk("t022_no_grant", 64'(last_acc), 0);
    chk("t022_idle", 64'(fsm_state), 64'(MDA_IDLE));
    flush[0] = 1'b0;
    req_valid = '0;

    // stray result pulse while Idle
    spur = 1'b1;
    tick();
    tick();
    chk("t024_idle_spurious", 64'(resp_valid), 0);

    // reset during Wait, then a fresh REMU
    mdu_lat = 5;
    set_req(1, 3'd5, 1'b0, 64'd100, 64'd7);
    accept(1);
    tick();
    chk("t036_in_wait", 64'(fsm_state), 64'(MDA_WAIT));
    rst = 1'b1;
    tick();
    for (int i = 0; i < NREQ; i++) exp_q[i].delete();
    req_valid[0] = 1'b1;
    #1;
    chk("t036_req_ready", 64'(req_ready), 0);
    chk("t036_mdu_valid", mdu_valid, 0);
    chk("t036_resp_valid", 64'(resp_valid), 0);
    chk("t036_resp_result1", resp_result[1], 0);
    chk("t036_mdu_op1", mdu_op1, 0);
    chk("t036_mdu_op2", mdu_op2, 0);
    chk("t036_busy", 64'(busy_cycles), 0);
    chk("t036_state", 64'(fsm_state), 64'(MDA_IDLE));
    req_valid = '0;
    rst = 1'b0;
    mdu_lat = 0;
    set_req(1, 3'd7, 1'b0, 64'd100, 64'd7);
    accept(1);
    wait_resp(1, 64'd2, "t036_remu", n);
    tick();

    // Issue stalled by mdu_ready, operands must come from the registers
    mdu_mode = 2;
    a = 64'hFEDC_BA98_7654_3210;
    b = 64'h0123_4567_89AB_CDEF;
    set_req(0, 3'd1, 1'b0, a, b);
    accept(0);
    req_op1[0] = 64'h5555; req_op2[0] = 64'hAAAA; req_funct3[0] = 3'd6;
    set_req(1, 3'd0, 1'b1, 64'hFFFF_FFFF_0000_0003, 64'd5);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t037_mdu_valid", mdu_valid, 1);
      chk("t037_op1", mdu_op1, a);
      chk("t037_op2", mdu_op2, b);
      chk("t037_funct3", 64'(mdu_funct3), 64'd1);
      chk("t037_req_ready", 64'(req_ready), 0);
      if (k == 2) spur = 1'b1;
      tick();
    end
    mdu_mode = 0;
    mdu_ready = 1'b1;
    wait_resp(0, ref_op(3'd1, 1'b0, a, b), "t037_mulh", n);
    accept(1);
    wait_resp(1, 64'd15, "t037_mulw", n);
    tick();

    // randomized traffic with back-pressure on both sides
    mdu_mode = 1;
    mdu_lat  = -1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last_acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rnd_op(), rnd_op());
        resp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    resp_ready = '1;
    mdu_mode = 0;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < NREQ; i++) if (last_acc[i]) req_valid[i] = 1'b0;
      if (req_valid == 0 && exp_q[0].size() == 0 && exp_q[1].size() == 0 && fsm_state == MDA_IDLE) break;
      tick();
    end
    chk("drain_pending_req", 64'(req_valid), 0);
    chk("drain_q0_empty", 64'(exp_q[0].size()), 0);
    chk("drain_q1_empty", 64'(exp_q[1].size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
